// File: rtl/mem_pair_sequencer.sv
// Command sequencer for the dual-write / read-ahead nibble memory: packs a nibble
// stream into paired writes and turns readback requests into offset memory reads.
module mem_pair_sequencer #(
    parameter int unsigned AW   = 4,
    parameter int unsigned DW   = 4,
    parameter int unsigned BASE = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    input  logic          in_last,
    input  logic          rb_valid,
    output logic          rb_ready,
    input  logic [AW-1:0] rb_addr,
    output logic          rb_rvalid,
    output logic [DW-1:0] rb_rdata,
    output logic [AW-1:0] addr,
    output logic [DW-1:0] wd1,
    output logic [DW-1:0] wd2,
    output logic          we1,
    output logic          we2,
    output logic          re,
    input  logic [DW-1:0] rd,
    output logic [AW:0]   frame_len
);

    localparam int unsigned CW = AW + 1;
    localparam logic [AW-1:0] BASE_P = AW'(BASE);
    localparam logic [CW-1:0] CNT_MAX = '1;

    typedef enum logic {
        EMPTY = 1'b0,
        HALF  = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [DW-1:0] held_q, held_d;
    logic [AW-1:0] ptr_q, ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] frame_len_q, frame_len_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wd1_q, wd1_d;
    logic [DW-1:0] wd2_q, wd2_d;
    logic          we1_q, we1_d;
    logic          we2_q, we2_d;
    logic          re_q, re_d;
    logic          rb_rvalid_q, rb_rvalid_d;
    logic          in_ready_q, in_ready_d;

    logic          accept_c;
    logic          wr_next_c;
    logic          rb_accept_c;
    logic [CW-1:0] cnt_inc_c;

    // Next-state, command generation and arbitration (writes win over readback).
    always_comb begin
        state_d     = state_q;
        held_d      = held_q;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        frame_len_d = frame_len_q;
        addr_d      = addr_q;
        wd1_d       = wd1_q;
        wd2_d       = wd2_q;
        we1_d       = 1'b0;
        we2_d       = 1'b0;
        re_d        = 1'b0;
        rb_rvalid_d = re_q;
        in_ready_d  = 1'b1;

        accept_c    = in_valid && in_ready_q;
        wr_next_c   = accept_c && ((state_q == HALF) || in_last);
        rb_ready    = !rst && !wr_next_c;
        rb_accept_c = rb_valid && rb_ready;
        cnt_inc_c   = (cnt_q == CNT_MAX) ? cnt_q : CW'(cnt_q + CW'(1));

        if (accept_c) begin
            if (in_last) begin
                frame_len_d = cnt_inc_c;
                cnt_d       = '0;
            end else begin
                cnt_d = cnt_inc_c;
            end

            case (state_q)
                EMPTY: begin
                    if (in_last) begin
                        addr_d = ptr_q;
                        wd1_d  = in_data;
                        we1_d  = 1'b1;
                        ptr_d  = BASE_P;
                    end else begin
                        held_d  = in_data;
                        state_d = HALF;
                    end
                end
                HALF: begin
                    addr_d  = ptr_q;
                    wd1_d   = held_q;
                    wd2_d   = in_data;
                    we1_d   = 1'b1;
                    we2_d   = 1'b1;
                    ptr_d   = in_last ? BASE_P : AW'(ptr_q + AW'(2));
                    state_d = EMPTY;
                end
                default: state_d = EMPTY;
            endcase
        end

        // The memory reads at addr+2, so pre-subtract to hit rb_addr.
        if (rb_accept_c) begin
            addr_d = AW'(rb_addr - AW'(2));
            re_d   = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= EMPTY;
            held_q      <= '0;
            ptr_q       <= BASE_P;
            cnt_q       <= '0;
            frame_len_q <= '0;
            addr_q      <= '0;
            wd1_q       <= '0;
            wd2_q       <= '0;
            we1_q       <= 1'b0;
            we2_q       <= 1'b0;
            re_q        <= 1'b0;
            rb_rvalid_q <= 1'b0;
            in_ready_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            held_q      <= held_d;
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
            frame_len_q <= frame_len_d;
            addr_q      <= addr_d;
            wd1_q       <= wd1_d;
            wd2_q       <= wd2_d;
            we1_q       <= we1_d;
            we2_q       <= we2_d;
            re_q        <= re_d;
            rb_rvalid_q <= rb_rvalid_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign rb_rvalid = rb_rvalid_q;
    assign rb_rdata  = rd;
    assign addr      = addr_q;
    assign wd1       = wd1_q;
    assign wd2       = wd2_q;
    assign we1       = we1_q;
    assign we2       = we2_q;
    assign re        = re_q;
    assign frame_len = frame_len_q;

endmodule

// File: tb/tb_mem_pair_sequencer.sv
// Scoreboard bench for mem_pair_sequencer: two instances (BASE=0 and BASE=14),
// each driving a behavioural nibble memory.
module tb_mem_pair_sequencer;

    typedef struct {
        logic [3:0] addr;
        logic [3:0] wd1;
        logic [3:0] wd2;
        logic       we1;
        logic       we2;
        logic       re;
    } cmd_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] in_data = '0;
    logic       in_last = 1'b0;
    logic       in_valid0 = 1'b0, in_valid1 = 1'b0;
    logic       rb_valid0 = 1'b0;
    logic [3:0] rb_addr0 = '0;
    logic       rb_valid1 = 1'b0;
    logic [3:0] rb_addr1 = '0;

    logic       in_ready0, rb_ready0, rb_rvalid0, we1_0, we2_0, re0;
    logic [3:0] rb_rdata0, addr0, wd1_0, wd2_0, rd0;
    logic [4:0] frame_len0;
    logic       in_ready1, rb_ready1, rb_rvalid1, we1_1, we2_1, re1;
    logic [3:0] rb_rdata1, addr1, wd1_1, wd2_1;
    logic [3:0] rd1 = '0;
    logic [4:0] frame_len1;

    logic [3:0] mem0 [16];
    cmd_t       q0[$];
    cmd_t       q1[$];
    logic [3:0] qr[$];
    int         n_cmp = 0;
    int         n_err = 0;

    always #5 clk = ~clk;

    mem_pair_sequencer #(.AW(4), .DW(4), .BASE(0)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid0), .in_ready(in_ready0),
        .in_data(in_data), .in_last(in_last), .rb_valid(rb_valid0), .rb_ready(rb_ready0),
        .rb_addr(rb_addr0), .rb_rvalid(rb_rvalid0), .rb_rdata(rb_rdata0), .addr(addr0),
        .wd1(wd1_0), .wd2(wd2_0), .we1(we1_0), .we2(we2_0), .re(re0), .rd(rd0),
        .frame_len(frame_len0)
    );

    mem_pair_sequencer #(.AW(4), .DW(4), .BASE(14)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
        .in_data(in_data), .in_last(in_last), .rb_valid(rb_valid1), .rb_ready(rb_ready1),
        .rb_addr(rb_addr1), .rb_rvalid(rb_rvalid1), .rb_rdata(rb_rdata1), .addr(addr1),
        .wd1(wd1_1), .wd2(wd2_1), .we1(we1_1), .we2(we2_1), .re(re1), .rd(rd1),
        .frame_len(frame_len1)
    );

    // Memory behind dut0: writes at addr/addr+1, registered read at addr+2.
    always @(posedge clk) begin
        if (we1_0) mem0[addr0] <= wd1_0;
        if (we2_0) mem0[4'(addr0 + 4'd1)] <= wd2_0;
        if (re0)   rd0 <= mem0[4'(addr0 + 4'd2)];
    end

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_cmd(input int id, input cmd_t act);
        cmd_t e;
        if (id == 0) begin
            if (q0.size() == 0) begin chk("dut0_unexpected_cmd", 1, 0); return; end
            e = q0.pop_front();
        end else begin
            if (q1.size() == 0) begin chk("dut1_unexpected_cmd", 1, 0); return; end
            e = q1.pop_front();
        end
        chk($sformatf("dut%0d_addr", id), act.addr, e.addr);
        chk($sformatf("dut%0d_we1", id), act.we1, e.we1);
        chk($sformatf("dut%0d_we2", id), act.we2, e.we2);
        chk($sformatf("dut%0d_re", id), act.re, e.re);
        if (e.we1) chk($sformatf("dut%0d_wd1", id), act.wd1, e.wd1);
        if (e.we2) chk($sformatf("dut%0d_wd2", id), act.wd2, e.wd2);
    endtask

    // Monitor: pops an expectation whenever a DUT presents a command or read data.
    always @(negedge clk) begin
        if (!rst) begin
            if (we1_0 || we2_0 || re0)
                check_cmd(0, '{addr0, wd1_0, wd2_0, we1_0, we2_0, re0});
            if (we1_1 || we2_1 || re1)
                check_cmd(1, '{addr1, wd1_1, wd2_1, we1_1, we2_1, re1});
            if (rb_rvalid0) begin
                if (qr.size() == 0) chk("unexpected_rvalid", 1, 0);
                else chk("rb_rdata", rb_rdata0, qr.pop_front());
            end
            if (rb_rvalid1) chk("dut1_spurious_rvalid", rb_rvalid1, 0);
        end
    end

    task automatic exp_w(input int id, input logic [3:0] a, input logic [3:0] d1,
                         input logic [3:0] d2, input logic w2);
        cmd_t c;
        c = '{a, d1, d2, 1'b1, w2, 1'b0};
        if (id == 0) q0.push_back(c); else q1.push_back(c);
    endtask

    task automatic exp_r(input logic [3:0] a, input logic [3:0] data);
        cmd_t c;
        c = '{a, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1};
        q0.push_back(c);
        qr.push_back(data);
    endtask

    task automatic send(input int id, input logic [3:0] d, input logic l);
        in_data = d;
        in_last = l;
        if (id == 0) in_valid0 = 1'b1; else in_valid1 = 1'b1;
        @(posedge clk); #1;
        in_valid0 = 1'b0;
        in_valid1 = 1'b0;
        in_last   = 1'b0;
    endtask

    task automatic rb_req(input logic [3:0] a);
        bit done;
        done = 1'b0;
        rb_addr0  = a;
        rb_valid0 = 1'b1;
        for (int i = 0; i < 4 && !done; i++) begin
            @(negedge clk);
            done = rb_ready0;
            @(posedge clk); #1;
        end
        rb_valid0 = 1'b0;
        if (!done) chk("rb_accept_timeout", 0, 1);
    endtask

    task automatic wait_ready();
        for (int i = 0; i < 8; i++) begin
            if (in_ready0 && in_ready1) break;
            @(posedge clk); #1;
        end
        chk("in_ready_after_reset", in_ready0 && in_ready1, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_addr", addr0, 0);
        chk("rst_we", {we1_0, we2_0, re0}, 0);
        chk("rst_in_ready", in_ready0, 0);
        chk("rst_rb_ready", rb_ready0, 0);
        chk("rst_frame_len", frame_len0, 0);
        rst = 1'b0;
        wait_ready();

        // Even frame 3,5,7,9.
        exp_w(0, 4'd0, 4'd3, 4'd5, 1'b1);
        exp_w(0, 4'd2, 4'd7, 4'd9, 1'b1);
        send(0, 4'd3, 1'b0);
        send(0, 4'd5, 1'b0);
        send(0, 4'd7, 1'b0);
        send(0, 4'd9, 1'b1);
        chk("frame_len_even", frame_len0, 4);

        // Readback with -2 offset; idle cycles hold addr.
        exp_r(4'd0, 4'd7);
        rb_req(4'd2);
        exp_r(4'd15, 4'd5);
        rb_req(4'd1);
        repeat (3) @(posedge clk);
        #1;
        chk("idle_addr_hold", addr0, 15);

        // Odd frame A,B,C restarts at BASE.
        exp_w(0, 4'd0, 4'hA, 4'hB, 1'b1);
        exp_w(0, 4'd2, 4'hC, 4'd0, 1'b0);
        send(0, 4'hA, 1'b0);
        send(0, 4'hB, 1'b0);
        send(0, 4'hC, 1'b1);
        chk("frame_len_odd", frame_len0, 3);

        // Readback blocked by pair completion, then read-after-write.
        send(0, 4'd1, 1'b0);
        exp_w(0, 4'd0, 4'd1, 4'd2, 1'b1);
        exp_r(4'd14, 4'd1);
        in_data   = 4'd2;
        in_valid0 = 1'b1;
        rb_addr0  = 4'd0;
        rb_valid0 = 1'b1;
        @(negedge clk);
        chk("rb_ready_blocked", rb_ready0, 0);
        @(posedge clk); #1;
        in_valid0 = 1'b0;
        rb_req(4'd0);
        exp_w(0, 4'd2, 4'd4, 4'd0, 1'b0);
        send(0, 4'd4, 1'b1);
        chk("frame_len_mixed", frame_len0, 3);
        repeat (2) @(posedge clk);
        #1;

        // Reset while HALF holding 6.
        send(0, 4'd6, 1'b0);
        rst = 1'b1;
        #1;
        chk("midrst_addr", addr0, 0);
        chk("midrst_wd1", wd1_0, 0);
        chk("midrst_frame_len", frame_len0, 0);
        chk("midrst_in_ready", in_ready0, 0);
        chk("midrst_rvalid", rb_rvalid0, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        wait_ready();
        exp_w(0, 4'd0, 4'd8, 4'd9, 1'b1);
        send(0, 4'd8, 1'b0);
        send(0, 4'd9, 1'b1);
        chk("frame_len_post_rst", frame_len0, 2);

        // BASE=14 instance: pair wraps from 14/15 to 0/1, then restarts at 14.
        exp_w(1, 4'd14, 4'd1, 4'd2, 1'b1);
        exp_w(1, 4'd0, 4'd3, 4'd4, 1'b1);
        exp_w(1, 4'd14, 4'd5, 4'd6, 1'b1);
        send(1, 4'd1, 1'b0);
        send(1, 4'd2, 1'b0);
        send(1, 4'd3, 1'b0);
        send(1, 4'd4, 1'b1);
        chk("dut1_frame_len", frame_len1, 4);
        send(1, 4'd5, 1'b0);
        send(1, 4'd6, 1'b1);
        chk("dut1_frame_len2", frame_len1, 2);

        repeat (4) @(posedge clk);
        #1;
        chk("q0_drained", q0.size(), 0);
        chk("q1_drained", q1.size(), 0);
        chk("qr_drained", qr.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
